inst_mem_responder: RTL and testbench



---
 rtl/inst_mem_responder.sv | 136 +++++++++++++
 tb/tb_inst_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: slave end of the instruction-fetch read bus.
// Serves one fetch request at a time from a word-addressed instruction RAM,
// with a loader write port for filling the RAM. Out-of-range or misaligned
// fetches return 32'h0 and set a sticky error flag.
// Optional feature (macro INST_MEM_RAND_WAIT_EN): an 8-bit LFSR adds 0..3
// random wait cycles to each accepted request to stress the master's hold logic.
module inst_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          DEPTH_WORDS = 1024,  // power of two, at least 2
  parameter int          LATENCY     = 1,     // 1..7
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_bus_addr_i,
  input  logic        inst_bus_avalid_i,
  output logic        inst_bus_valid_o,
  output logic [31:0] inst_bus_data_o,
  input  logic        ld_en_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Wide enough for LATENCY-1 plus up to 3 random extra cycles.
  localparam int CW = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic [CW-1:0]   wait_init;
  logic [31:0]     rd_addr;
  logic [31:0]     rd_off;
  logic [AW-1:0]   rd_idx;
  logic            rd_bad;
  logic [31:0]     rd_word;
  logic [31:0]     ld_off;
  logic [AW-1:0]   ld_idx;
  logic            ld_ok;

  // A request is taken whenever nothing is counting down; taking one in RESP
  // gives back-to-back service.
  assign accept = inst_bus_avalid_i && (state_q != ST_WAIT);

`ifdef INST_MEM_RAND_WAIT_EN
  logic [7:0] lfsr_q, lfsr_d;
  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running every cycle.
  assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign wait_init = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);

  // LFSR register, seeded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign wait_init = CW'(LATENCY - 1);
`endif

  // The RAM is read on the edge that enters RESP. With a zero-wait request
  // that is the accept edge itself, so the live bus address is used then.
  assign rd_addr = accept ? inst_bus_addr_i : addr_q;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_idx  = rd_off[AW+1:2];
  assign rd_bad  = ((rd_off >> (AW + 2)) != 32'd0) || (rd_addr[1:0] != 2'b00);

  assign ld_off  = ld_addr_i - BASE_ADDR;
  assign ld_idx  = ld_off[AW+1:2];
  assign ld_ok   = ld_en_i && ((ld_off >> (AW + 2)) == 32'd0) && (ld_addr_i[1:0] == 2'b00);

  // Write-first: a loader write to the word being read this edge is forwarded.
  assign rd_word = (ld_ok && (ld_idx == rd_idx)) ? ld_data_i : mem[rd_idx];

  // Loader write port; illegal writes are dropped silently.
  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_idx] <= ld_data_i;
  end

  // Next-state logic: accept, count down, respond for one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    if (accept) begin
      addr_d  = inst_bus_addr_i;
      cnt_d   = wait_init;
      state_d = (wait_init == '0) ? ST_RESP : ST_WAIT;
    end else begin
      case (state_q)
        ST_WAIT: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = ST_RESP;
        end
        ST_RESP: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
    if (state_d == ST_RESP) begin
      data_d = rd_bad ? 32'h0 : rd_word;
      err_d  = err_q | rd_bad;
    end
  end

  // Control and response registers; RAM contents are never reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign inst_bus_valid_o = (state_q == ST_RESP);
  assign inst_bus_data_o  = data_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Testbench for inst_mem_responder: directed vector table, hand-written
// multi-cycle sequences (LATENCY 1/3/4 instances) and a randomized
// back-to-back fetch run checked against a memory reference model.
module tb_inst_mem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        avalid;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  logic        v1, v3, v4, e1, e3, e4;
  logic [31:0] d1, d3, d4;

  logic [31:0] model [DEPTH];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_mem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .inst_bus_addr_i(addr), .inst_bus_avalid_i(avalid),
    .inst_bus_valid_o(v1), .inst_bus_data_o(d1),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .err_o(e1));

  inst_mem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .inst_bus_addr_i(addr), .inst_bus_avalid_i(avalid),
    .inst_bus_valid_o(v3), .inst_bus_data_o(d3),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .err_o(e3));

  inst_mem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(DEPTH), .LATENCY(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .inst_bus_addr_i(addr), .inst_bus_avalid_i(avalid),
    .inst_bus_valid_o(v4), .inst_bus_data_o(d4),
    .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .err_o(e4));

  typedef struct {
    logic [31:0] addr;
    logic        avalid;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    avalid = 1'b0;
    ld_en  = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_word(input int idx, input logic [31:0] val);
    ld_en   = 1'b1;
    ld_addr = idx * 4;
    ld_data = val;
    tick();
    ld_en = 1'b0;
    model[idx] = val;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    addr = 32'h0; avalid = 1'b0; ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    rst_n = 1'b0;
    #12;
    check("reset_valid", {31'b0, v1}, 32'h0);
    check("reset_data",  d1, 32'h0);
    check("reset_err",   {31'b0, e1}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Preload the RAM of all instances through the loader port.
    for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
    load_word(0, 32'h00000013);
    load_word(1, 32'h00100093);

`ifndef INST_MEM_RAND_WAIT_EN
    // Vector table on the LATENCY=1 instance: back-to-back, hold, errors.
    tbl[0] = '{32'h0,          1'b1, 1'b1, model[0],      1'b0};
    tbl[1] = '{32'h4,          1'b1, 1'b1, model[1],      1'b0};
    tbl[2] = '{32'h0,          1'b0, 1'b0, model[1],      1'b0};
    tbl[3] = '{DEPTH * 4,      1'b1, 1'b1, 32'h0,         1'b1};
    tbl[4] = '{32'h2,          1'b1, 1'b1, 32'h0,         1'b1};
    tbl[5] = '{32'h0,          1'b0, 1'b0, 32'h0,         1'b1};
    tbl[6] = '{32'h8,          1'b1, 1'b1, model[2],      1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      addr   = tbl[i].addr;
      avalid = tbl[i].avalid;
      tick();
      check($sformatf("tbl%0d_valid", i), {31'b0, v1}, {31'b0, tbl[i].exp_valid});
      check($sformatf("tbl%0d_data", i),  d1, tbl[i].exp_data);
      check($sformatf("tbl%0d_err", i),   {31'b0, e1}, {31'b0, tbl[i].exp_err});
    end
    avalid = 1'b0;
    tick();

    // Illegal loader writes must be dropped without touching err.
    do_reset();
    ld_en = 1'b1; ld_addr = DEPTH * 4; ld_data = 32'hBAD0BAD0;
    tick();
    ld_addr = 32'h6; ld_data = 32'hBAD1BAD1;
    tick();
    ld_en = 1'b0;
    addr = 32'h0; avalid = 1'b1;
    tick();
    check("ld_oor_word0", d1, model[0]);
    addr = 32'h4;
    tick();
    check("ld_misal_word1", d1, model[1]);
    check("ld_drop_err", {31'b0, e1}, 32'h0);
    avalid = 1'b0;
    tick();

    // Same-word write and read on one edge: write-first.
    addr = 32'h10; avalid = 1'b1;
    ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'hDEADBEEF;
    tick();
    ld_en = 1'b0; avalid = 1'b0;
    model[4] = 32'hDEADBEEF;
    check("coll_valid", {31'b0, v1}, 32'h1);
    check("coll_data", d1, 32'hDEADBEEF);
    tick();
    avalid = 1'b1;
    tick();
    check("coll_reread", d1, 32'hDEADBEEF);
    avalid = 1'b0;
    tick();

    // LATENCY=3: address change during WAIT is ignored, then taken at RESP.
    do_reset();
    addr = 32'h8; avalid = 1'b1;
    tick();
    check("l3_c1_valid", {31'b0, v3}, 32'h0);
    addr = 32'hC;
    tick();
    check("l3_c2_valid", {31'b0, v3}, 32'h0);
    tick();
    check("l3_c3_valid", {31'b0, v3}, 32'h1);
    check("l3_c3_data", d3, model[2]);
    tick();
    check("l3_c4_valid", {31'b0, v3}, 32'h0);
    avalid = 1'b0;
    tick();
    check("l3_c5_valid", {31'b0, v3}, 32'h0);
    tick();
    check("l3_c6_valid", {31'b0, v3}, 32'h1);
    check("l3_c6_data", d3, model[3]);
    tick();
    check("l3_c7_valid", {31'b0, v3}, 32'h0);

    // LATENCY=4: reset during WAIT abandons the request.
    do_reset();
    addr = 32'h0; avalid = 1'b1;
    tick();
    avalid = 1'b0;
    check("l4_c1_valid", {31'b0, v4}, 32'h0);
    tick();
    check("l4_c2_valid", {31'b0, v4}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("l4_rst_valid", {31'b0, v4}, 32'h0);
    check("l4_rst_err", {31'b0, e4}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("l4_post_rst%0d", i), {31'b0, v4}, 32'h0);
    end
    avalid = 1'b1; addr = 32'h0;
    tick();
    avalid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("l4_lat%0d_valid", i), {31'b0, v4}, (i == 4) ? 32'h1 : 32'h0);
      if (i < 4) tick();
    end
    check("l4_data", d4, model[0]);
    check("l4_err", {31'b0, e4}, 32'h0);
    tick();
`endif

    // Randomized back-to-back fetches on the LATENCY=1 instance; the master
    // holds its address until valid, then presents the next one.
    begin
      int lat_max;
      int cur_idx;
      int lat;
`ifdef INST_MEM_RAND_WAIT_EN
      lat_max = 4;
`else
      lat_max = 1;
`endif
      do_reset();
      cur_idx = $urandom_range(0, DEPTH - 1);
      addr = cur_idx * 4; avalid = 1'b1;
      tick();
      for (int n = 0; n < 200; n++) begin
        lat = 1;
        while (v1 !== 1'b1 && lat < 10) begin
          tick();
          lat++;
        end
        checks++;
        if (v1 !== 1'b1 || lat > lat_max) begin
          failures++;
          $display("FAIL rnd%0d_latency actual=%0d required=1..%0d", n, lat, lat_max);
        end
        check($sformatf("rnd%0d_data", n), d1, model[cur_idx]);
        if (n < 199) begin
          cur_idx = $urandom_range(0, DEPTH - 1);
          addr = cur_idx * 4;
        end else begin
          avalid = 1'b0;
        end
        tick();
      end
      check("rnd_err", {31'b0, e1}, 32'h0);
      tick();
      check("rnd_idle_valid", {31'b0, v1}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
